csa_accum_seq: RTL and testbench
================================

CSA_ACCUM_SEQ -- requirements
Module: csa_accum_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, operand-count field width; result width RW = WIDTH+CNT_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  pulse to begin a job; sampled only in IDLE.
REQ-006 SHALL have port num_ops  input  CNT_W  operand count for the job; sampled with start.
REQ-007 SHALL have port op_valid  input  1  operand available.
REQ-008 SHALL have port op_data  input  WIDTH  operand, unsigned, zero-extended to RW.
REQ-009 SHALL have port op_ready  output  1  block accepts operand this cycle.
REQ-010 SHALL have port res_valid  output  1  result available.
REQ-011 SHALL have port res_data  output  RW  accumulated sum.
REQ-012 SHALL have port res_ready  input  1  consumer accepts result.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, RESOLVE, DONE.
REQ-015 IDLE: start=1 and num_ops!=0 SHALL latch remaining count = num_ops, clear sum register S and carry register C (both RW bits) to 0, go to ACCUM.
REQ-016 IDLE: start=1 and num_ops==0 SHALL load res_data=0 and go directly to DONE.
REQ-017 IDLE: start=0 SHALL remain in IDLE; start SHALL be ignored in all other states.
REQ-018 op_ready SHALL be 1 only in ACCUM; operand transfer occurs when op_valid&op_ready.
REQ-019 Each transfer SHALL perform one 3:2 carry-save step: S' = S ^ C ^ X, C' = ((S&C)|(S&X)|(C&X)) << 1, truncated to RW bits, X = zero-extended op_data.
REQ-020 Each transfer SHALL decrement remaining count; the transfer with remaining==1 SHALL move FSM to RESOLVE.
REQ-021 ACCUM with op_valid=0 SHALL hold S, C, count unchanged (stall, no timeout).
REQ-022 RESOLVE SHALL last exactly one cycle, register res_data = (S + C) mod 2^RW, then go to DONE.
REQ-023 DONE: res_valid SHALL be 1; res_data SHALL stay stable until res_ready=1.
REQ-024 DONE with res_ready=1 SHALL return to IDLE next cycle; res_valid SHALL drop to 0 in that cycle.
REQ-025 res_valid SHALL be 0 in IDLE, ACCUM, RESOLVE.
REQ-026 Latency: res_valid SHALL rise 2 cycles after the last operand transfer edge (1 RESOLVE, then DONE).
REQ-027 Back-to-back: start asserted in the first IDLE cycle after DONE SHALL be accepted; minimum job period = num_ops + 3 cycles with no stalls.
REQ-028 With num_ops = 2^CNT_W-1 and all operands 2^WIDTH-1 the result SHALL not overflow RW bits.
REQ-029 res_data SHALL hold its last value in IDLE until the next RESOLVE or zero-count start overwrites it.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, S=0, C=0, count=0, res_data=0, in any state including mid-ACCUM or DONE.
REQ-031 During and after reset, until a new start: op_ready=0, res_valid=0, busy=0.
REQ-032 A job interrupted by reset SHALL be discarded; no partial result SHALL be presented.

Verification
REQ-033 WIDTH=16: start, num_ops=3, operands 5, 7, 9 with op_valid continuously high -> res_valid 2 cycles after third transfer, res_data=21.
REQ-034 num_ops=15, all operands 0xFFFF -> res_data=0xEFFF1 (983025), no truncation.
REQ-035 num_ops=0 -> DONE next cycle, res_data=0, op_ready never asserted.
REQ-036 num_ops=2, op_valid gapped 3 cycles between 100 and 200; res_ready held 0 for 4 cycles in DONE -> res_data=300 stable whole time, FSM to IDLE the cycle after res_ready=1.
REQ-037 rst_n=0 after 2 of 4 operands accepted -> IDLE, busy=0, op_ready=0; subsequent job num_ops=1 operand 42 -> res_data=42.
REQ-038 start pulsed while in ACCUM or DONE -> no effect on count, S, C or result.

Source files
------------

// File: rtl/csa_accum_seq.sv
// csa_accum_seq: multi-operand accumulator built on a 3:2 carry-save step.
// A job adds num_ops unsigned operands. Sum and carry vectors are kept
// redundant while operands stream in. A single carry-propagate add in
// RESOLVE turns them into the final result, which is then held in DONE
// until the consumer takes it.
module csa_accum_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4,
  localparam int RW   = WIDTH + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             res_valid,
  output logic [RW-1:0]    res_data,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]    RW_ZERO  = {RW{1'b0}};

  // Sum bit of a 3:2 compressor: bitwise parity of the three inputs.
  function automatic logic [RW-1:0] csa_sum(input logic [RW-1:0] a,
                                            input logic [RW-1:0] b,
                                            input logic [RW-1:0] c);
    csa_sum = a ^ b ^ c;
  endfunction

  // Carry of a 3:2 compressor: bitwise majority, moved up one weight.
  // The bit shifted out of the top is dropped (arithmetic is mod 2^RW).
  function automatic logic [RW-1:0] csa_carry(input logic [RW-1:0] a,
                                              input logic [RW-1:0] b,
                                              input logic [RW-1:0] c);
    logic [RW-1:0] maj;
    maj       = (a & b) | (a & c) | (b & c);
    csa_carry = {maj[RW-2:0], 1'b0};
  endfunction

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [RW-1:0]     s_r;
  logic [RW-1:0]     c_r;
  logic [RW-1:0]     res_data_r;
  logic              op_ready_r;
  logic              res_valid_r;
  logic              busy_r;

  logic [RW-1:0]     x_ext_s;
  logic [RW-1:0]     sum_next_s;
  logic [RW-1:0]     carry_next_s;

  // Next carry-save pair for the operand currently on op_data.
  always_comb begin
    x_ext_s      = {{CNT_W{1'b0}}, op_data};
    sum_next_s   = csa_sum(s_r, c_r, x_ext_s);
    carry_next_s = csa_carry(s_r, c_r, x_ext_s);
  end

  // Job FSM; handshake outputs are registered together with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      s_r         <= RW_ZERO;
      c_r         <= RW_ZERO;
      res_data_r  <= RW_ZERO;
      op_ready_r  <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
            if (num_ops != CNT_ZERO) begin
              cnt_r      <= num_ops;
              s_r        <= RW_ZERO;
              c_r        <= RW_ZERO;
              op_ready_r <= 1'b1;
              state_r    <= ACCUM;
            end else begin
              // Empty job: the result is zero and no operands are taken.
              res_data_r  <= RW_ZERO;
              res_valid_r <= 1'b1;
              state_r     <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (op_valid && op_ready_r) begin
            s_r   <= sum_next_s;
            c_r   <= carry_next_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              op_ready_r <= 1'b0;
              state_r    <= RESOLVE;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            // Stall: producer has nothing, keep everything as is.
            state_r <= ACCUM;
          end
        end
        RESOLVE: begin
          res_data_r  <= s_r + c_r;
          res_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          op_ready_r  <= 1'b0;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready  = op_ready_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_csa_accum_seq.sv
// Bench for csa_accum_seq: directed and random jobs. Expected results are
// plain sums of the operands, queued at job issue and checked by an
// independent monitor whenever res_valid is high.
module tb_csa_accum_seq;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int RW    = WIDTH + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             op_valid;
  logic [WIDTH-1:0] op_data;
  logic             op_ready;
  logic             res_valid;
  logic [RW-1:0]    res_data;
  logic             res_ready;
  logic             busy;

  int n_cmp = 0;
  int n_mis = 0;
  logic [RW-1:0]    exp_q[$];
  logic [WIDTH-1:0] ops [0:15];

  csa_accum_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a result is presented it must match the head of
  // the scoreboard; the entry is retired when the consumer accepts it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_result: got %0d expected none (t=%0t)", res_data, $time);
      end else begin
        chk("res_data", {44'd0, res_data}, {44'd0, exp_q[0]});
        if (res_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // Issues one job using ops[0..n-1]. Entered and left at posedge+1 in IDLE.
  task automatic run_job(input int n, input int gap, input int rdly, input bit poke);
    logic [RW-1:0] expv;
    expv = '0;
    for (int i = 0; i < n; i++) expv = expv + RW'(ops[i]);
    exp_q.push_back(expv);
    start   = 1'b1;
    num_ops = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done_valid", res_valid, 1);
      chk("zero_op_ready", op_ready, 0);
    end else begin
      chk("busy_accum", busy, 1);
      for (int i = 0; i < n; i++) begin
        if (i > 0 && gap > 0) begin
          op_valid = 1'b0;
          op_data  = 16'hDEAD;
          for (int g = 0; g < gap; g++) begin
            if (poke) begin start = 1'b1; num_ops = CNT_W'($urandom_range(0, 15)); end
            @(posedge clk); #1;
            start = 1'b0;
            chk("stall_op_ready", op_ready, 1);
            chk("stall_res_valid", res_valid, 0);
          end
        end
        op_valid = 1'b1;
        op_data  = ops[i];
        chk("op_ready", op_ready, 1);
        @(posedge clk); #1;
      end
      op_valid = 1'b0;
      chk("resolve_valid", res_valid, 0);
      chk("resolve_op_ready", op_ready, 0);
      @(posedge clk); #1;
      chk("latency_valid", res_valid, 1);
    end
    for (int d = 0; d < rdly; d++) begin
      if (poke) begin start = 1'b1; num_ops = CNT_W'($urandom_range(0, 15)); end
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_hold_valid", res_valid, 1);
      chk("done_busy", busy, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_valid", res_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_op_ready", op_ready, 0);
    chk("idle_hold_data", {44'd0, res_data}, {44'd0, expv});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_ops = '0; op_valid = 1'b0;
    op_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", {44'd0, res_data}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 + 7 + 9
    ops[0] = 16'd5; ops[1] = 16'd7; ops[2] = 16'd9;
    run_job(3, 0, 0, 1'b0);
    chk("sum_5_7_9", {44'd0, res_data}, 64'd21);

    // Full-scale job: fifteen 0xFFFF operands.
    for (int i = 0; i < 15; i++) ops[i] = 16'hFFFF;
    run_job(15, 0, 1, 1'b0);
    chk("max_no_overflow", {44'd0, res_data}, 64'd983025);

    // Empty job.
    run_job(0, 0, 0, 1'b0);
    chk("zero_result", {44'd0, res_data}, 64'd0);

    // Gapped operands, delayed consumer, start pokes in ACCUM and DONE.
    ops[0] = 16'd100; ops[1] = 16'd200;
    run_job(2, 3, 4, 1'b1);
    chk("gapped_sum", {44'd0, res_data}, 64'd300);

    // Reset after two of four operands.
    start = 1'b1; num_ops = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; op_data = 16'(1000 + i);
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_op_ready", op_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data", {44'd0, res_data}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_busy", busy, 0);
    chk("postrst_res_valid", res_valid, 0);
    ops[0] = 16'd42;
    run_job(1, 0, 0, 1'b0);
    chk("after_reset_sum", {44'd0, res_data}, 64'd42);

    // Random back-to-back jobs.
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) ops[i] = 16'($urandom);
      run_job(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
